// File: rtl/vga_pkg.sv
// Shared constants, types and colour helper for the VGA cell renderer.
package vga_pkg;

    localparam int unsigned H_VISIBLE  = 640;
    localparam int unsigned V_VISIBLE  = 480;
    localparam int unsigned CELL_SHIFT = 5;
    localparam int unsigned COLS       = H_VISIBLE >> CELL_SHIFT;
    localparam int unsigned ROWS       = V_VISIBLE >> CELL_SHIFT;
    localparam int unsigned CELLS      = COLS * ROWS;

    typedef logic [7:0] rgb332_t;

    typedef enum logic {CLEAR, RUN} render_state_t;

    // Replicate the top bits so full-scale 3/2-bit values map to 8'hFF.
    function automatic logic [23:0] rgb332_to_rgb888(input rgb332_t c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_cell_renderer_if.sv
// Cell-write request channel into the renderer.
interface vga_cell_renderer_if;
    import vga_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_addr;
    rgb332_t    wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/cell_ram.sv
// 300x8 simple dual-port cell RAM, synchronous read-first output.
module cell_ram
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we_i,
    input  logic [8:0] waddr_i,
    input  rgb332_t    wdata_i,
    input  logic [8:0] raddr_i,
    output rgb332_t    rdata_o
);

    localparam logic [8:0] CellsW = 9'(CELLS);

    rgb332_t mem [CELLS];
    rgb332_t rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < CellsW)) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Reads out of range (off-screen rows/columns) return black.
    always_comb begin
        rdata_d = '0;
        if (raddr_i < CellsW) begin
            rdata_d = mem[raddr_i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_cell_renderer.sv
// Renders a 20x15 grid of 32x32 coloured cells with grid overlay and blinking cursor,
// keeping syncs and enable aligned with the two-stage colour pipeline.
module vga_cell_renderer
    import vga_pkg::*;
#(
    parameter bit          GRID_EN      = 1'b1,
    parameter rgb332_t     GRID_COLOR   = 8'hFF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_ce,
    input  logic [9:0]                x_in,
    input  logic [9:0]                y_in,
    input  logic                      de_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    vga_cell_renderer_if.slave        wr,
    input  logic [4:0]                cursor_col,
    input  logic [3:0]                cursor_row,
    input  logic                      cursor_en,
    output logic [7:0]                red,
    output logic [7:0]                green,
    output logic [7:0]                blue,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      de_out,
    output logic                      frame_start
);

    localparam logic [8:0]  CellsW    = 9'(CELLS);
    localparam logic [8:0]  LastCell  = 9'(CELLS - 1);
    localparam logic [15:0] LastFrame = 16'(BLINK_FRAMES - 1);

    render_state_t state_q, state_d;
    logic [8:0]    clr_addr_q, clr_addr_d;
    logic          ram_we;
    logic [8:0]    ram_waddr;
    rgb332_t       ram_wdata;
    rgb332_t       cell_rd;
    logic          ready;

    // Stage 1
    logic [8:0] addr_q, addr_d;
    logic [4:0] xlo_q, xlo_d, ylo_q, ylo_d;
    logic       hit_q, hit_d, de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    // Stage 2
    logic [23:0] rgb_q, rgb_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    // Frame / blink
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        blink_q, blink_d;

    logic [8:0] row9, col9, cell_idx;
    rgb332_t    sel;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ram_we     = 1'b0;
        ram_waddr  = wr.wr_addr;
        ram_wdata  = wr.wr_data;
        ready      = 1'b0;
        unique case (state_q)
            CLEAR: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + 9'd1;
                if (clr_addr_q == LastCell) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end
            end
            RUN: begin
                ready  = 1'b1;
                ram_we = wr.wr_valid && (wr.wr_addr < CellsW);
            end
            default: state_d = CLEAR;
        endcase
    end

    assign wr.wr_ready = ready;

    cell_ram u_cell_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (addr_q),
        .rdata_o (cell_rd)
    );

    always_comb begin
        row9     = {4'b0, y_in[9:5]};
        col9     = {4'b0, x_in[9:5]};
        cell_idx = (row9 << 4) + (row9 << 2) + col9;

        sel = cell_rd;
        if (!de1_q || (state_q == CLEAR)) begin
            sel = '0;
        end else if (GRID_EN && ((xlo_q == 5'd0) || (ylo_q == 5'd0))) begin
            sel = GRID_COLOR;
        end else if (hit_q && blink_q) begin
            sel = ~cell_rd;
        end

        addr_d = addr_q;
        xlo_d  = xlo_q;
        ylo_d  = ylo_q;
        hit_d  = hit_q;
        de1_d  = de1_q;
        hs1_d  = hs1_q;
        vs1_d  = vs1_q;
        rgb_d  = rgb_q;
        hs2_d  = hs2_q;
        vs2_d  = vs2_q;
        de2_d  = de2_q;
        if (pix_ce) begin
            addr_d = cell_idx;
            xlo_d  = x_in[4:0];
            ylo_d  = y_in[4:0];
            hit_d  = cursor_en && (x_in[9:5] == cursor_col) &&
                     (y_in[9:5] == {1'b0, cursor_row});
            de1_d  = de_in;
            hs1_d  = hsync_in;
            vs1_d  = vsync_in;
            rgb_d  = rgb332_to_rgb888(sel);
            hs2_d  = hs1_q;
            vs2_d  = vs1_q;
            de2_d  = de1_q;
        end

        frame_start_d = pix_ce && (x_in == 10'd0) && (y_in == 10'd0);
        frame_cnt_d   = frame_cnt_q;
        blink_d       = blink_q;
        if (frame_start_q) begin
            if (frame_cnt_q == LastFrame) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= CLEAR;
            clr_addr_q    <= '0;
            addr_q        <= '0;
            xlo_q         <= '0;
            ylo_q         <= '0;
            hit_q         <= 1'b0;
            de1_q         <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            rgb_q         <= '0;
            hs2_q         <= 1'b0;
            vs2_q         <= 1'b0;
            de2_q         <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            blink_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            addr_q        <= addr_d;
            xlo_q         <= xlo_d;
            ylo_q         <= ylo_d;
            hit_q         <= hit_d;
            de1_q         <= de1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            rgb_q         <= rgb_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            de2_q         <= de2_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_q       <= blink_d;
        end
    end

    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign de_out      = de2_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Directed bench for vga_cell_renderer: the bench drives pix_ce and x/y directly so
// frames, strobes and write timing are fully controlled.
module tb_vga_cell_renderer;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic       de_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [4:0] cursor_col = '0;
    logic [3:0] cursor_row = '0;
    logic       cursor_en = 1'b0;
    logic [7:0] red, green, blue;
    logic       hsync_out, vsync_out, de_out, frame_start;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    vga_cell_renderer_if wr_if ();

    vga_cell_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .x_in        (x_in),
        .y_in        (y_in),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .wr          (wr_if),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .cursor_en   (cursor_en),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .de_out      (de_out),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after a strobe edge, as from the sync generator.
    task automatic strobe(input int x, input int y, input logic de, input logic hs,
                          input logic vs);
        x_in = 10'(x); y_in = 10'(y); de_in = de; hsync_in = hs; vsync_in = vs;
        pix_ce = 1'b0;
        tick;
        pix_ce = 1'b1;
        tick;
        pix_ce = 1'b0;
    endtask

    // After two strobes of the same pixel the outputs show that pixel.
    task automatic show(input int x, input int y);
        strobe(x, y, 1'b1, 1'b0, 1'b0);
        strobe(x, y, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic write_cell(input int addr, input logic [7:0] data);
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 9'(addr); wr_if.wr_data = data;
        tick;
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (wr_if.wr_ready !== 1'b1 && n < 1000) begin
            tick;
            n++;
        end
        total++;
        if (n != 300) begin
            bad++;
            $display("FAIL %s: wr_ready rose after %0d clks, want 300", name, n);
        end
    endtask

    task automatic test_reset;
        int  n;
        logic blk_ok;
        reset = 1'b1; x_in = 10'd64; y_in = 10'd32; de_in = 1'b1;
        repeat (3) tick;
        total++;
        if ({red, green, blue} !== 24'h0 || {hsync_out, vsync_out, de_out, frame_start} !== 4'b0
            || wr_if.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rgb=%h hs/vs/de/fs=%b%b%b%b ready=%b, want all 0",
                     {red, green, blue}, hsync_out, vsync_out, de_out, frame_start,
                     wr_if.wr_ready);
        end
        reset = 1'b0;
        n = 0;
        blk_ok = 1'b1;
        // Grid pixel would be white in RUN; it must stay black while clearing.
        while (wr_if.wr_ready !== 1'b1 && n < 1000) begin
            pix_ce = ~pix_ce;
            tick;
            n++;
            if ({red, green, blue} !== 24'h0) blk_ok = 1'b0;
        end
        pix_ce = 1'b0;
        total++;
        if (n != 300) begin
            bad++;
            $display("FAIL clear_length: wr_ready rose after %0d clks, want 300", n);
        end
        total++;
        if (!blk_ok) begin
            bad++;
            $display("FAIL clear_black: colour seen during CLEAR, want black");
        end
    endtask

    task automatic test_cell_colour;
        write_cell(21, 8'hE0);
        write_cell(5, 8'h1C);
        write_cell(299, 8'h92);
        show(40, 40);
        total++;
        if ({red, green, blue} !== 24'hFF0000 || de_out !== 1'b1) begin
            bad++;
            $display("FAIL cell21_red: rgb=%h de=%b, want ff0000 de=1", {red, green, blue}, de_out);
        end
        show(168, 8);
        total++;
        if ({red, green, blue} !== 24'h00FF00) begin
            bad++;
            $display("FAIL cell5_green: rgb=%h, want 00ff00", {red, green, blue});
        end
        show(616, 456);
        total++;
        if ({red, green, blue} !== 24'h9292AA) begin
            bad++;
            $display("FAIL cell299_mix: rgb=%h, want 9292aa", {red, green, blue});
        end
    endtask

    task automatic test_grid;
        show(64, 32);
        total++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL grid_corner: rgb=%h, want ffffff", {red, green, blue});
        end
        show(32, 40);
        total++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL grid_vline_over_red: rgb=%h, want ffffff", {red, green, blue});
        end
        show(40, 32);
        total++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL grid_hline_over_red: rgb=%h, want ffffff", {red, green, blue});
        end
        show(639, 479);
        total++;
        if ({red, green, blue} !== 24'h9292AA) begin
            bad++;
            $display("FAIL last_pixel: rgb=%h, want 9292aa", {red, green, blue});
        end
    endtask

    task automatic test_read_first;
        strobe(40, 40, 1'b1, 1'b0, 1'b0);
        // Write lands on the same clk the RAM reads cell 21 for this pixel.
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = 9'd21; wr_if.wr_data = 8'h03;
        tick;
        wr_if.wr_valid = 1'b0;
        pix_ce = 1'b1;
        tick;
        pix_ce = 1'b0;
        total++;
        if ({red, green, blue} !== 24'hFF0000) begin
            bad++;
            $display("FAIL read_first_old: rgb=%h, want ff0000", {red, green, blue});
        end
        show(40, 40);
        total++;
        if ({red, green, blue} !== 24'h0000FF) begin
            bad++;
            $display("FAIL read_first_new: rgb=%h, want 0000ff", {red, green, blue});
        end
    endtask

    task automatic test_sync;
        int   hs_first_in, hs_first_out, vs_first_in, vs_first_out, hs_clks, vs_clks, xv;
        logic vis_ok, hs, vs;
        strobe(700, 10, 1'b0, 1'b0, 1'b0);
        strobe(700, 10, 1'b0, 1'b0, 1'b0);
        hs_first_in = -1; hs_first_out = -1; vs_first_in = -1; vs_first_out = -1;
        hs_clks = 0; vs_clks = 0; vis_ok = 1'b1;
        for (int i = 0; i < 164; i++) begin
            xv = (640 + i) % 800;
            hs = (xv >= 656 && xv < 752);
            vs = (xv >= 700 && xv < 703);
            x_in = 10'(xv); y_in = 10'd10; de_in = 1'b0; hsync_in = hs; vsync_in = vs;
            if (hs && hs_first_in < 0) hs_first_in = cyc;
            if (vs && vs_first_in < 0) vs_first_in = cyc;
            for (int k = 0; k < 2; k++) begin
                pix_ce = (k == 1);
                tick;
                if (hsync_out) begin
                    hs_clks++;
                    if (hs_first_out < 0) hs_first_out = cyc;
                end
                if (vsync_out) begin
                    vs_clks++;
                    if (vs_first_out < 0) vs_first_out = cyc;
                end
                if (de_out !== 1'b0 || {red, green, blue} !== 24'h0) vis_ok = 1'b0;
            end
            pix_ce = 1'b0;
        end
        total++;
        if (hs_clks != 192) begin
            bad++;
            $display("FAIL hsync_width: %0d clks, want 192", hs_clks);
        end
        total++;
        if (hs_first_out - hs_first_in != 4) begin
            bad++;
            $display("FAIL hsync_delay: %0d clks, want 4", hs_first_out - hs_first_in);
        end
        total++;
        if (vs_clks != 6) begin
            bad++;
            $display("FAIL vsync_width: %0d clks, want 6", vs_clks);
        end
        total++;
        if (vs_first_out - vs_first_in != 4) begin
            bad++;
            $display("FAIL vsync_delay: %0d clks, want 4", vs_first_out - vs_first_in);
        end
        total++;
        if (!vis_ok) begin
            bad++;
            $display("FAIL blanking: de_out or colour active outside visible area, want 0");
        end
    endtask

    task automatic test_wr_range;
        int idx [4] = '{0, 10, 44, 54};
        total++;
        if (wr_if.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_in_run: wr_ready=%b, want 1", wr_if.wr_ready);
        end
        write_cell(300, 8'h55);
        write_cell(310, 8'hAA);
        foreach (idx[i]) begin
            show((idx[i] % 20) * 32 + 8, (idx[i] / 20) * 32 + 8);
            total++;
            if ({red, green, blue} !== 24'h0) begin
                bad++;
                $display("FAIL range_cell%0d: rgb=%h, want 000000", idx[i], {red, green, blue});
            end
        end
    endtask

    task automatic test_clear_midrun;
        reset = 1'b1;
        tick;
        tick;
        total++;
        if ({red, green, blue} !== 24'h0 || wr_if.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: rgb=%h ready=%b, want 000000 0", {red, green, blue},
                     wr_if.wr_ready);
        end
        reset = 1'b0;
        wait_clear("midrun_clear_length");
        for (int c = 0; c < 300; c++) begin
            show((c % 20) * 32 + 8, (c / 20) * 32 + 8);
            total++;
            if ({red, green, blue} !== 24'h0) begin
                bad++;
                $display("FAIL cleared_cell%0d: rgb=%h, want 000000", c, {red, green, blue});
            end
        end
    endtask

    task automatic test_cursor;
        write_cell(0, 8'h03);
        cursor_col = 5'd0; cursor_row = 4'd0; cursor_en = 1'b1;
        show(8, 8);
        total++;
        if ({red, green, blue} !== 24'h0000FF) begin
            bad++;
            $display("FAIL cursor_blink0: rgb=%h, want 0000ff", {red, green, blue});
        end
        strobe(0, 0, 1'b0, 1'b0, 1'b0);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL frame_start_pulse: got %b, want 1", frame_start);
        end
        tick;
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL frame_start_width: got %b, want 0", frame_start);
        end
        strobe(1, 0, 1'b0, 1'b0, 1'b0);
        strobe(0, 1, 1'b0, 1'b0, 1'b0);
        x_in = 10'd0; y_in = 10'd0; pix_ce = 1'b0;
        tick;
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL frame_start_spurious: got %b, want 0", frame_start);
        end
        repeat (28) strobe(0, 0, 1'b0, 1'b0, 1'b0);
        show(8, 8);
        total++;
        if ({red, green, blue} !== 24'h0000FF) begin
            bad++;
            $display("FAIL cursor_29_frames: rgb=%h, want 0000ff", {red, green, blue});
        end
        strobe(0, 0, 1'b0, 1'b0, 1'b0);
        show(8, 8);
        total++;
        if ({red, green, blue} !== 24'hFFFF00) begin
            bad++;
            $display("FAIL cursor_inverted: rgb=%h, want ffff00", {red, green, blue});
        end
        cursor_en = 1'b0;
        show(8, 8);
        total++;
        if ({red, green, blue} !== 24'h0000FF) begin
            bad++;
            $display("FAIL cursor_disabled: rgb=%h, want 0000ff", {red, green, blue});
        end
        cursor_en = 1'b1; cursor_col = 5'd1;
        show(40, 8);
        total++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL cursor_moved: rgb=%h, want ffffff", {red, green, blue});
        end
        show(8, 8);
        total++;
        if ({red, green, blue} !== 24'h0000FF) begin
            bad++;
            $display("FAIL old_cursor_cell: rgb=%h, want 0000ff", {red, green, blue});
        end
        repeat (30) strobe(0, 0, 1'b0, 1'b0, 1'b0);
        show(40, 8);
        total++;
        if ({red, green, blue} !== 24'h000000) begin
            bad++;
            $display("FAIL cursor_blink_back: rgb=%h, want 000000", {red, green, blue});
        end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;
        test_reset();
        test_cell_colour();
        test_grid();
        test_read_first();
        test_sync();
        test_wr_range();
        test_clear_midrun();
        test_cursor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_cell_renderer.md
# vga_cell_renderer

Pixel-generation stage directly downstream of the 640x480 HV sync generator. It consumes the generator's pixel strobe, x/y counters, enable and sync outputs. It renders a 20x15 grid of 32x32-pixel coloured cells from an internal cell RAM, with an optional grid overlay and a blinking cursor cell. It delays hsync/vsync so they stay aligned with the RGB data sent to the VGA DAC.

## Interface
- GRID_EN, 1, draw 1-pixel grid lines when 1
- GRID_COLOR, 8'hFF, RGB332 colour of grid lines
- BLINK_FRAMES, 30, frames per cursor blink half-period
- clk  in  1  system clock, 50 MHz
- reset  in  1  reset, asynchronous, active-high
- pix_ce  in  1  pixel strobe from sync generator, high 1 clk in 2
- x_in  in  10  horizontal pixel counter
- y_in  in  10  vertical line counter
- de_in  in  1  visible-region enable
- hsync_in  in  1  hsync, active-high during retrace
- vsync_in  in  1  vsync, active-high during retrace
- wr_valid  in  1  cell write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  9  cell index, row*20+col, 0..299
- wr_data  in  8  RGB332 cell colour
- cursor_col  in  5  cursor cell column 0..19
- cursor_row  in  4  cursor cell row 0..14
- cursor_en  in  1  enable cursor
- red, green, blue  out  8 each  pixel colour to DAC
- hsync_out, vsync_out  out  1  delayed syncs
- de_out  out  1  delayed enable
- frame_start  out  1  1-clk pulse at start of each frame

## Operation
- FSM states are CLEAR and RUN. Reset enters CLEAR with clr_addr=0.
- CLEAR writes 8'h00 to one cell per clk, addresses 0..299. After writing 299 it moves to RUN. wr_ready=0 throughout CLEAR.
- In RUN, wr_ready=1. An accepted write with wr_addr>=300 is ignored and is not an error.
- Cell RAM: 300x8, simple dual-port, synchronous read. When a read and a write hit the same address in the same clk, the read returns the old data (read-first).
- Cell index = y_in[9:5]*20 + x_in[9:5], computed as (r<<4)+(r<<2)+c, 9 bits.
- Colour selection, in priority order:
  - de=0 or FSM in CLEAR: output black.
  - GRID_EN=1 and (x[4:0]==0 or y[4:0]==0): GRID_COLOR.
  - Cursor cell and cursor_en and blink=1: bitwise-inverted cell colour.
  - Otherwise: the cell colour.
- RGB332 to 8-bit expansion:
  - red = {r3,r3,r2[2:1]}
  - green = {g3,g3,g2[2:1]}
  - blue = {b2,b2,b2,b2}
- Blink: a frame counter, 0..BLINK_FRAMES-1, advances on each frame_start. On wrap, blink toggles.
- frame_start: a 1-clk pulse on the pix_ce cycle where x_in==0 and y_in==0.

## Timing
- The pipeline advances only on clk edges with pix_ce=1.
- Stage 1 registers the RAM address, the x/y low bits, the cursor-hit flag and the sync/de inputs.
- Stage 2 registers the final RGB, hsync_out, vsync_out and de_out.
- Latency is 2 pix_ce strobes (4 clks) from inputs to outputs. Syncs and de take exactly the same delay as colour.
- Reset values:
  - red/green/blue = 0
  - hsync_out = vsync_out = de_out = 0
  - frame_start = 0
  - wr_ready = 0
  - blink = 0, frame counter = 0
- Reset mid-CLEAR or mid-RUN returns to CLEAR at address 0. RAM contents are not otherwise reset.
- CLEAR lasts exactly 300 clks after reset deasserts; wr_ready rises on clk 301.
- Cursor position is sampled in stage 1 and may change at any time.

## Structure
- Package vga_pkg holds:
  - constants H_VISIBLE=640, V_VISIBLE=480, CELL_SHIFT=5, COLS=20, ROWS=15, CELLS=300
  - typedef rgb332_t
  - typedef enum {CLEAR, RUN} render_state_t
  - function rgb332_to_rgb888
- One sub-module, cell_ram (300x8 simple dual-port, read-first). All other logic lives in the top level.

## Test plan
- Reset released -> wr_ready low for 300 clks, then high; colour outputs black during CLEAR; every cell reads 8'h00 afterwards.
- Write addr 21 = 8'hE0, GRID_EN=0, present x=40,y=40,de=1 -> 2 strobes later red=8'hFF, green=0, blue=0.
- GRID_EN=1, x=64 or y=32 in the visible region -> output is the expansion of GRID_COLOR (white for 8'hFF), regardless of cell colour.
- hsync_in pulse at x=656..751 -> hsync_out identical pulse width, delayed 4 clks; de_out low and RGB black outside 640x480.
- cursor at (0,0), cell 0 = 8'h03, cursor_en=1 -> alternates blue and 8'hFC every 30 frames; frame_start pulses once per 800x525 strobes.
- Write addr 310 -> ignored, cells 0..299 unchanged; same-address read/write in one clk -> old colour shown for that pixel.
